// File: rtl/lcd_pkg.sv
// Shared constants and FSM encoding for the HD44780 16x2 character driver.
package lcd_pkg;

   // HD44780 command bytes
   localparam logic [7:0] CMD_FUNC_8BIT_2LINE = 8'h38;
   localparam logic [7:0] CMD_DISP_ON         = 8'h0C;
   localparam logic [7:0] CMD_CLEAR           = 8'h01;
   localparam logic [7:0] CMD_ENTRY_INC       = 8'h06;
   localparam logic [7:0] CMD_ADDR_L1         = 8'h80;
   localparam logic [7:0] CMD_ADDR_L2         = 8'h C0;

   // Blank character used as the snapshot contents after reset
   localparam logic [7:0] CHAR_SPACE = 8'h20;

   typedef enum logic [2:0] {
      PWR_WAIT,
      INIT,
      LOAD,
      ADDR1,
      LINE1,
      ADDR2,
      LINE2,
      IDLE
   } lcd_state_t;

   // Power-up command sequence, indexed by init step 0..3
   function automatic logic [7:0] init_cmd(input logic [1:0] i_step);
      logic [7:0] v_cmd;
      case (i_step)
         2'd0:    v_cmd = CMD_FUNC_8BIT_2LINE;
         2'd1:    v_cmd = CMD_DISP_ON;
         2'd2:    v_cmd = CMD_CLEAR;
         default: v_cmd = CMD_ENTRY_INC;
      endcase
      return v_cmd;
   endfunction

endpackage

// File: rtl/lcd_write_cycle.sv
// One LCD bus write: a setup cycle, T_EN_HIGH cycles of EN, then the
// post-write wait. RS/DATA are held from the start of one write until the
// next one is accepted, so they are stable for the whole write window.
// A new write may be accepted in the last wait cycle of the previous one
// (o_ready), which lets writes run back to back with no idle cycle.
module lcd_write_cycle
   import lcd_pkg::*;
#(
   parameter int T_EN_HIGH = 25,
   parameter int T_CMD     = 2500,
   parameter int T_CLEAR   = 82000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic       i_rs,
   input  logic [7:0] i_data,
   input  logic       i_is_clear,
   output logic       o_rs,
   output logic [7:0] o_data,
   output logic       o_en,
   output logic       o_done,
   output logic       o_ready
);

   localparam int T_WAIT_MAX = (T_CLEAR > T_CMD) ? T_CLEAR : T_CMD;
   localparam int CW         = $clog2(T_EN_HIGH + T_WAIT_MAX + 1);

   // Cycle indices within a write: 0 = setup, 1..T_EN_HIGH = EN high, rest = wait
   localparam logic [CW-1:0] C_EN_LAST  = CW'(T_EN_HIGH);
   localparam logic [CW-1:0] C_CMD_LAST = CW'(T_EN_HIGH + T_CMD);
   localparam logic [CW-1:0] C_CLR_LAST = CW'(T_EN_HIGH + T_CLEAR);

   logic          r_active;
   logic          r_is_clear;
   logic          r_en;
   logic          r_rs;
   logic [7:0]    r_data;
   logic [CW-1:0] r_cnt;
   logic          w_last;

   assign w_last  = (r_cnt == (r_is_clear ? C_CLR_LAST : C_CMD_LAST));
   assign o_done  = r_active && w_last;
   assign o_ready = !r_active || w_last;
   assign o_rs    = r_rs;
   assign o_data  = r_data;
   assign o_en    = r_en;

   // Write sequencer: latch bus values on start, step the cycle counter, register EN.
   // The caller must only assert i_start while o_ready is high.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_active   <= 1'b0;
         r_is_clear <= 1'b0;
         r_en       <= 1'b0;
         r_rs       <= 1'b0;
         r_data     <= 8'h00;
         r_cnt      <= '0;
      end else if (i_start) begin
         r_active   <= 1'b1;
         r_is_clear <= i_is_clear;
         r_en       <= 1'b0;
         r_rs       <= i_rs;
         r_data     <= i_data;
         r_cnt      <= '0;
      end else if (r_active) begin
         // EN is high for the cycles whose index will be 1..T_EN_HIGH
         r_en <= !w_last && (r_cnt < C_EN_LAST);
         if (w_last) begin
            r_active <= 1'b0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/lcd_char_driver.sv
// Drives a 16x2 HD44780 LCD in 8-bit write-only mode from 32 character
// inputs. After power-up init it writes a full frame, then rewrites the
// whole frame from a fresh snapshot whenever any input differs from the
// snapshot. The FSM runs one write ahead of the bus: it advances when a
// write is accepted, and only waits for completion on the very last write.
module lcd_char_driver
   import lcd_pkg::*;
#(
   parameter int T_POWERUP = 750000,
   parameter int T_EN_HIGH = 25,
   parameter int T_CMD     = 2500,
   parameter int T_CLEAR   = 82000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] LCD0,  LCD1,  LCD2,  LCD3,  LCD4,  LCD5,  LCD6,  LCD7,
   input  logic [7:0] LCD8,  LCD9,  LCD10, LCD11, LCD12, LCD13, LCD14, LCD15,
   input  logic [7:0] LCD16, LCD17, LCD18, LCD19, LCD20, LCD21, LCD22, LCD23,
   input  logic [7:0] LCD24, LCD25, LCD26, LCD27, LCD28, LCD29, LCD30, LCD31,
   output logic [7:0] LCD_DATA,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic       LCD_EN,
   output logic       LCD_ON,
   output logic       LCD_BLON,
   output logic       BUSY,
   output logic       FRAME_DONE
);

   localparam int PW = $clog2(T_POWERUP + 1);
   localparam logic [PW-1:0] C_PWR_LAST = PW'(T_POWERUP - 1);

   lcd_state_t    r_state;
   lcd_state_t    r_state_next;
   logic [7:0]    w_live [32];
   logic [7:0]    r_snap [32];
   logic [31:0]   w_diff;
   logic [4:0]    r_idx;
   logic [PW-1:0] r_pwr_cnt;
   logic          r_last_issued;
   logic          r_frame_done;

   logic          w_start;
   logic          w_rs;
   logic [7:0]    w_data;
   logic          w_is_clear;
   logic          w_wr_done;
   logic          w_wr_ready;

   assign w_live = '{LCD0,  LCD1,  LCD2,  LCD3,  LCD4,  LCD5,  LCD6,  LCD7,
                     LCD8,  LCD9,  LCD10, LCD11, LCD12, LCD13, LCD14, LCD15,
                     LCD16, LCD17, LCD18, LCD19, LCD20, LCD21, LCD22, LCD23,
                     LCD24, LCD25, LCD26, LCD27, LCD28, LCD29, LCD30, LCD31};

   // Per-character change detect between live inputs and the displayed snapshot
   generate
      for (genvar gi = 0; gi < 32; gi++) begin : g_diff
         assign w_diff[gi] = (w_live[gi] != r_snap[gi]);
      end
   endgenerate

   lcd_write_cycle #(
      .T_EN_HIGH (T_EN_HIGH),
      .T_CMD     (T_CMD),
      .T_CLEAR   (T_CLEAR)
   ) u_write (
      .i_clk      (CLK),
      .i_rst      (RST),
      .i_start    (w_start),
      .i_rs       (w_rs),
      .i_data     (w_data),
      .i_is_clear (w_is_clear),
      .o_rs       (LCD_RS),
      .o_data     (LCD_DATA),
      .o_en       (LCD_EN),
      .o_done     (w_wr_done),
      .o_ready    (w_wr_ready)
   );

   assign LCD_RW     = 1'b0;
   assign LCD_ON     = 1'b1;
   assign LCD_BLON   = 1'b1;
   assign BUSY       = (r_state != IDLE);
   assign FRAME_DONE = r_frame_done;

   // FSM state register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= PWR_WAIT;
      end else begin
         r_state <= r_state_next;
      end
   end

   // Next state and the write request presented to the write sequencer
   always_comb begin
      r_state_next = r_state;
      w_start      = 1'b0;
      w_rs         = 1'b0;
      w_data       = 8'h00;
      w_is_clear   = 1'b0;
      case (r_state)
         PWR_WAIT: begin
            if (r_pwr_cnt == C_PWR_LAST) r_state_next = INIT;
         end
         INIT: begin
            w_data     = init_cmd(r_idx[1:0]);
            w_is_clear = (w_data == CMD_CLEAR);
            w_start    = w_wr_ready;
            if (w_start && (r_idx == 5'd3)) r_state_next = LOAD;
         end
         LOAD: begin
            r_state_next = ADDR1;
         end
         ADDR1: begin
            w_data  = CMD_ADDR_L1;
            w_start = w_wr_ready;
            if (w_start) r_state_next = LINE1;
         end
         LINE1: begin
            w_rs    = 1'b1;
            w_data  = r_snap[r_idx];
            w_start = w_wr_ready;
            if (w_start && (r_idx == 5'd15)) r_state_next = ADDR2;
         end
         ADDR2: begin
            w_data  = CMD_ADDR_L2;
            w_start = w_wr_ready;
            if (w_start) r_state_next = LINE2;
         end
         LINE2: begin
            w_rs    = 1'b1;
            w_data  = r_snap[r_idx];
            w_start = w_wr_ready && !r_last_issued;
            if (r_last_issued && w_wr_done) r_state_next = IDLE;
         end
         IDLE: begin
            if (|w_diff) r_state_next = LOAD;
         end
         default: r_state_next = PWR_WAIT;
      endcase
   end

   // Power-up counter, write index, last-write flag and frame-done pulse
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_pwr_cnt     <= '0;
         r_idx         <= 5'd0;
         r_last_issued <= 1'b0;
         r_frame_done  <= 1'b0;
      end else begin
         r_frame_done <= (r_state == LINE2) && r_last_issued && w_wr_done;
         case (r_state)
            PWR_WAIT: begin
               if (r_pwr_cnt != C_PWR_LAST) r_pwr_cnt <= r_pwr_cnt + 1'b1;
            end
            INIT: begin
               if (w_start) r_idx <= (r_idx == 5'd3) ? 5'd0 : r_idx + 5'd1;
            end
            LOAD: begin
               r_idx         <= 5'd0;
               r_last_issued <= 1'b0;
            end
            LINE1: begin
               // Index 15 rolls to 16 here; ADDR2 sits between the two lines
               if (w_start) r_idx <= r_idx + 5'd1;
            end
            LINE2: begin
               if (w_start) begin
                  if (r_idx == 5'd31) r_last_issued <= 1'b1;
                  else                r_idx <= r_idx + 5'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Frame snapshot: blank after reset, captured in full in LOAD
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int k = 0; k < 32; k++) r_snap[k] <= CHAR_SPACE;
      end else if (r_state == LOAD) begin
         for (int k = 0; k < 32; k++) r_snap[k] <= w_live[k];
      end
   end

endmodule
